// File: rtl/video_scan_gen.sv
// Raster scan generator: pixel strobe divider, H/V timing, sync decode,
// scrolled character-cell coordinates, frame counter and line/vblank events.
module video_scan_gen #(
  parameter int   PIX_DIV   = 4,
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter int   HSZ       = 10,
  parameter int   VSZ       = 10,
  parameter int   CELL_W    = 8,
  parameter int   CELL_H    = 8,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   FRAME_W   = 6
) (
  input  logic                       clk_100mhz,
  input  logic                       rstn_i,
  input  logic                       i_enable,
  input  logic [HSZ-1:0]             i_scroll_x,
  input  logic [VSZ-1:0]             i_scroll_y,
  output logic                       o_pix_en,
  output logic [HSZ-1:0]             o_hcount,
  output logic [VSZ-1:0]             o_vcount,
  output logic                       o_de,
  output logic                       o_hsync,
  output logic                       o_vsync,
  output logic [$clog2(CELL_W)-1:0]  o_cell_col,
  output logic [$clog2(CELL_H)-1:0]  o_glyph_row,
  output logic [HSZ-1:0]             o_text_col,
  output logic [VSZ-1:0]             o_text_row,
  output logic [FRAME_W-1:0]         o_frame_count,
  output logic                       o_line_start,
  output logic                       o_vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(PIX_DIV);
  localparam int CW_B    = $clog2(CELL_W);
  localparam int CH_B    = $clog2(CELL_H);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [HSZ-1:0]   H_LAST   = HSZ'(H_TOTAL - 1);
  localparam logic [HSZ-1:0]   H_ACT    = HSZ'(H_ACTIVE);
  localparam logic [HSZ-1:0]   HS_BEG   = HSZ'(H_ACTIVE + H_FP);
  localparam logic [HSZ-1:0]   HS_END   = HSZ'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VSZ-1:0]   V_LAST   = VSZ'(V_TOTAL - 1);
  localparam logic [VSZ-1:0]   V_ACT    = VSZ'(V_ACTIVE);
  localparam logic [VSZ-1:0]   VS_BEG   = VSZ'(V_ACTIVE + V_FP);
  localparam logic [VSZ-1:0]   VS_END   = VSZ'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [HSZ:0]     H_MOD    = (HSZ+1)'(H_ACTIVE);
  localparam logic [VSZ:0]     V_MOD    = (VSZ+1)'(V_ACTIVE);

  typedef enum logic {STARTUP, RUN} state_t;

  // One extra bit keeps position+scroll from overflowing before the wrap.
  function automatic logic [HSZ-1:0] mod_h(input logic [HSZ:0] v);
    logic [HSZ:0] r;
    r = v % H_MOD;
    return r[HSZ-1:0];
  endfunction

  function automatic logic [VSZ-1:0] mod_v(input logic [VSZ:0] v);
    logic [VSZ:0] r;
    r = v % V_MOD;
    return r[VSZ-1:0];
  endfunction

  state_t             state, state_nx;
  logic [DIV_W-1:0]   div;
  logic               tick;
  logic [HSZ-1:0]     scx, scx_nx, h_nx, sx;
  logic [VSZ-1:0]     scy, scy_nx, v_nx, sy;
  logic [FRAME_W-1:0] frame_nx;

  assign tick = i_enable && (div == DIV_LAST);

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      div <= '0;
    end else if (i_enable) begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= STARTUP;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    h_nx     = o_hcount;
    v_nx     = o_vcount;
    frame_nx = o_frame_count;
    scx_nx   = scx;
    scy_nx   = scy;
    if (tick) begin
      case (state)
        STARTUP: begin
          h_nx     = '0;
          v_nx     = '0;
          scx_nx   = mod_h({1'b0, i_scroll_x});
          scy_nx   = mod_v({1'b0, i_scroll_y});
          state_nx = RUN;
        end
        RUN: begin
          if (o_hcount == H_LAST) begin
            h_nx = '0;
            if (o_vcount == V_LAST) begin
              v_nx     = '0;
              frame_nx = o_frame_count + 1'b1;
              scx_nx   = mod_h({1'b0, i_scroll_x});
              scy_nx   = mod_v({1'b0, i_scroll_y});
            end else begin
              v_nx = o_vcount + 1'b1;
            end
          end else begin
            h_nx = o_hcount + 1'b1;
          end
        end
        default: state_nx = STARTUP;
      endcase
    end
    sx = mod_h({1'b0, h_nx} + {1'b0, scx_nx});
    sy = mod_v({1'b0, v_nx} + {1'b0, scy_nx});
  end

  // Output register: everything advances on the strobe edge and holds between strobes.
  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      o_pix_en       <= 1'b0;
      o_hcount       <= '0;
      o_vcount       <= '0;
      o_de           <= 1'b0;
      o_hsync        <= ~HSYNC_POL;
      o_vsync        <= ~VSYNC_POL;
      o_cell_col     <= '0;
      o_glyph_row    <= '0;
      o_text_col     <= '0;
      o_text_row     <= '0;
      o_frame_count  <= '0;
      o_line_start   <= 1'b0;
      o_vblank_start <= 1'b0;
      scx            <= '0;
      scy            <= '0;
    end else begin
      o_pix_en       <= tick;
      o_line_start   <= tick && (h_nx == '0);
      o_vblank_start <= tick && (h_nx == '0) && (v_nx == V_ACT);
      if (tick) begin
        o_hcount      <= h_nx;
        o_vcount      <= v_nx;
        o_frame_count <= frame_nx;
        scx           <= scx_nx;
        scy           <= scy_nx;
        o_de          <= (h_nx < H_ACT) && (v_nx < V_ACT);
        o_hsync       <= ((h_nx >= HS_BEG) && (h_nx <= HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        o_vsync       <= ((v_nx >= VS_BEG) && (v_nx <= VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        o_cell_col    <= sx[CW_B-1:0];
        o_text_col    <= sx >> CW_B;
        o_glyph_row   <= sy[CH_B-1:0];
        o_text_row    <= sy >> CH_B;
      end
    end
  end

endmodule

// File: tb/tb_video_scan_gen.sv
// Directed bench for video_scan_gen on a small 20x11 raster (16x8 visible,
// 4x2 cells, active-high hsync, 2-bit frame counter).
module tb_video_scan_gen;

  localparam int HA = 16, HT = 20, VA = 8, VT = 11, CW = 4, CH = 2;

  logic       clk_100mhz = 1'b0;
  logic       rstn_i;
  logic       i_enable;
  logic [9:0] i_scroll_x, i_scroll_y;
  logic       o_pix_en, o_de, o_hsync, o_vsync, o_line_start, o_vblank_start;
  logic [9:0] o_hcount, o_vcount, o_text_col, o_text_row;
  logic [1:0] o_cell_col;
  logic [0:0] o_glyph_row;
  logic [1:0] o_frame_count;

  int checks = 0, failures = 0;
  int eh, ev, ef, lsx, lsy;
  bit started;

  video_scan_gen #(
    .PIX_DIV(4), .H_ACTIVE(HA), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(VA), .V_FP(1), .V_SYNC(1), .V_BP(1), .HSZ(10), .VSZ(10),
    .CELL_W(CW), .CELL_H(CH), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .FRAME_W(2)
  ) dut (
    .clk_100mhz(clk_100mhz), .rstn_i(rstn_i), .i_enable(i_enable),
    .i_scroll_x(i_scroll_x), .i_scroll_y(i_scroll_y), .o_pix_en(o_pix_en),
    .o_hcount(o_hcount), .o_vcount(o_vcount), .o_de(o_de), .o_hsync(o_hsync),
    .o_vsync(o_vsync), .o_cell_col(o_cell_col), .o_glyph_row(o_glyph_row),
    .o_text_col(o_text_col), .o_text_row(o_text_row), .o_frame_count(o_frame_count),
    .o_line_start(o_line_start), .o_vblank_start(o_vblank_start)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pix_en"}, o_pix_en, 0);
    chk({tag, "_hcount"}, o_hcount, 0);
    chk({tag, "_vcount"}, o_vcount, 0);
    chk({tag, "_de"}, o_de, 0);
    chk({tag, "_hsync"}, o_hsync, 0);
    chk({tag, "_vsync"}, o_vsync, 1);
    chk({tag, "_cell_col"}, o_cell_col, 0);
    chk({tag, "_glyph_row"}, o_glyph_row, 0);
    chk({tag, "_text_col"}, o_text_col, 0);
    chk({tag, "_text_row"}, o_text_row, 0);
    chk({tag, "_frame"}, o_frame_count, 0);
    chk({tag, "_line_start"}, o_line_start, 0);
    chk({tag, "_vblank_start"}, o_vblank_start, 0);
  endtask

  // Reference raster position; scroll is sampled when the DUT would latch it.
  task automatic advance_model();
    if (!started) begin
      eh = 0; ev = 0; started = 1;
      lsx = int'(i_scroll_x) % HA; lsy = int'(i_scroll_y) % VA;
    end else if (eh == HT - 1) begin
      eh = 0;
      if (ev == VT - 1) begin
        ev = 0; ef = (ef + 1) % 4;
        lsx = int'(i_scroll_x) % HA; lsy = int'(i_scroll_y) % VA;
      end else begin
        ev++;
      end
    end else begin
      eh++;
    end
  endtask

  task automatic check_outputs();
    int sx, sy;
    sx = (eh + lsx) % HA;
    sy = (ev + lsy) % VA;
    chk("hcount", o_hcount, eh);
    chk("vcount", o_vcount, ev);
    chk("de", o_de, (eh < HA && ev < VA) ? 1 : 0);
    chk("hsync", o_hsync, (eh == 17 || eh == 18) ? 1 : 0);
    chk("vsync", o_vsync, (ev == 9) ? 0 : 1);
    chk("cell_col", o_cell_col, sx % CW);
    chk("text_col", o_text_col, sx / CW);
    chk("glyph_row", o_glyph_row, sy % CH);
    chk("text_row", o_text_row, sy / CH);
    chk("frame", o_frame_count, ef);
    chk("line_start", o_line_start, (eh == 0) ? 1 : 0);
    chk("vblank_start", o_vblank_start, (eh == 0 && ev == VA) ? 1 : 0);
  endtask

  task automatic next_strobe(input int exp_gap);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk_100mhz);
      n++;
      if (o_pix_en === 1'b1 || n >= 32) break;
    end
    chk("strobe_gap", n, exp_gap);
    advance_model();
    check_outputs();
  endtask

  task automatic run_to_origin();
    for (int i = 0; i < HT * VT; i++) begin
      next_strobe(4);
      if (eh == 0 && ev == 0) break;
    end
  endtask

  initial begin
    rstn_i = 1'b0; i_enable = 1'b1; i_scroll_x = '0; i_scroll_y = '0;
    started = 0; ef = 0; eh = 0; ev = 0; lsx = 0; lsy = 0;
    repeat (3) @(negedge clk_100mhz);
    check_reset("reset");

    // Release and first strobe at (0,0) four clocks later.
    rstn_i = 1'b1;
    next_strobe(4);
    chk("first_h", o_hcount, 0);
    chk("first_de", o_de, 1);
    chk("first_frame", o_frame_count, 0);

    // Four full frames: frame counter walks 1,2,3 and wraps back to 0.
    for (int i = 0; i < HT * VT * 4; i++) begin
      next_strobe(4);
      if (eh == 0 && ev == 0) chk("frame_seq", o_frame_count, (i + 1) / (HT * VT) % 4);
    end
    chk("frame_wrap", o_frame_count, 0);

    // Scroll written mid-frame only shows after the next frame boundary.
    repeat (50) next_strobe(4);
    i_scroll_x = 10'd3; i_scroll_y = 10'd0;
    repeat (5) next_strobe(4);
    run_to_origin();
    chk("scroll3_h0_cell", o_cell_col, 3);
    chk("scroll3_h0_text", o_text_col, 0);
    next_strobe(4);
    chk("scroll3_h1_cell", o_cell_col, 0);
    chk("scroll3_h1_text", o_text_col, 1);

    i_scroll_x = 10'd15; i_scroll_y = 10'd5;
    run_to_origin();
    chk("scroll15_h0_text", o_text_col, 3);
    chk("scroll5_v0_glyph", o_glyph_row, 1);
    chk("scroll5_v0_row", o_text_row, 2);
    next_strobe(4);
    chk("scroll15_h1_text", o_text_col, 0);
    chk("scroll15_h1_cell", o_cell_col, 0);

    // Scroll beyond the active width reduces modulo the active size.
    i_scroll_x = 10'd19; i_scroll_y = 10'd9;
    run_to_origin();
    chk("scroll19_cell", o_cell_col, 3);
    chk("scroll9_glyph", o_glyph_row, 1);
    chk("scroll9_row", o_text_row, 0);

    // Pause for 10 clocks one clock after a strobe; position holds, no strobes.
    repeat (7) next_strobe(4);
    @(negedge clk_100mhz);
    chk("pause_pre_pix_en", o_pix_en, 0);
    i_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_100mhz);
      chk("pause_pix_en", o_pix_en, 0);
      chk("pause_hold_h", o_hcount, eh);
      chk("pause_line_start", o_line_start, 0);
    end
    i_enable = 1'b1;
    next_strobe(3);
    repeat (30) next_strobe(4);

    // Asynchronous reset mid-frame, then restart through STARTUP.
    @(negedge clk_100mhz);
    #2 rstn_i = 1'b0;
    #1 check_reset("async_reset");
    @(negedge clk_100mhz);
    check_reset("held_reset");
    rstn_i = 1'b1;
    started = 0; ef = 0;
    next_strobe(4);
    chk("restart_h", o_hcount, 0);
    chk("restart_v", o_vcount, 0);
    repeat (HT + 5) next_strobe(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_scan_gen.md
Name: video_scan_gen

Overview:
- Parametrised successor to the fixed 640x480 pixel-clock divider, VGA timing and glyph/text-row counting logic in the graphics generator top level.
- Runs entirely on clk_100mhz. Produces a one-cycle pixel-enable strobe instead of a derived clock.
- Generates programmable H/V timing, sync polarity, scrolled character-cell coordinates, frame counter and frame/line event pulses.
- Consumed by the text area, the canvas and the register/CPU interface.

Parameters:
- PIX_DIV, 4: clk_100mhz cycles per pixel, >=2.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HSZ, 10: width of the horizontal count and x scroll.
- VSZ, 10: width of the vertical count and y scroll.
- CELL_W, 8: cell width in pixels, power of two.
- CELL_H, 8: cell height in lines, power of two.
- HSYNC_POL, 0: asserted level of o_hsync.
- VSYNC_POL, 0: asserted level of o_vsync.
- FRAME_W, 6: width of the frame counter.

Ports:
- clk_100mhz, in, 1: system clock.
- rstn_i, in, 1: asynchronous reset, active low.
- i_enable, in, 1: run when 1, freeze when 0.
- i_scroll_x, in, HSZ: x scroll offset.
- i_scroll_y, in, VSZ: y scroll offset.
- o_pix_en, out, 1: one-cycle pixel strobe.
- o_hcount, out, HSZ: raw horizontal position.
- o_vcount, out, VSZ: raw vertical position.
- o_de, out, 1: display enable (active area).
- o_hsync, out, 1: horizontal sync.
- o_vsync, out, 1: vertical sync.
- o_cell_col, out, log2(CELL_W): pixel column within the cell.
- o_glyph_row, out, log2(CELL_H): pixel row within the cell.
- o_text_col, out, HSZ: character column.
- o_text_row, out, VSZ: character row.
- o_frame_count, out, FRAME_W: frame counter.
- o_line_start, out, 1: one-cycle pulse at the start of each line.
- o_vblank_start, out, 1: one-cycle pulse at the start of vertical blanking.

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Reset is asynchronous on rstn_i low, releasing on the next clock edge after rstn_i rises. Values held in reset:
  - all counters, o_frame_count and all coordinate outputs = 0;
  - o_de = 0, o_pix_en = 0, o_line_start = 0, o_vblank_start = 0;
  - o_hsync = ~HSYNC_POL, o_vsync = ~VSYNC_POL;
  - internal started = 0; scroll latches = 0.
- Divider: div counts 0..PIX_DIV-1 while i_enable=1. o_pix_en is registered and high for exactly one clk when div wraps to 0, so period = PIX_DIV clocks.
  - First o_pix_en occurs PIX_DIV clocks after reset release with i_enable=1.
- Scan state (states STARTUP, RUN):
  - All scan outputs update on the clock edge where o_pix_en rises and hold for PIX_DIV clocks. Downstream samples them while o_pix_en=1 on the following edge.
  - STARTUP: the first strobe loads pixel (0,0) and latches the scroll inputs. The frame count is not incremented. Go to RUN.
  - RUN, normal: hcount increments each strobe.
  - RUN, end of line: at H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - RUN, end of frame: at (H_TOTAL-1, V_TOTAL-1), both wrap to 0, o_frame_count increments modulo 2^FRAME_W, and i_scroll_x/i_scroll_y are latched.
- Scroll is applied only at the frame boundary; mid-frame changes have no visible effect until the next frame.
- Decoded outputs, registered in the same cycle as hcount/vcount:
  - o_de = (hcount<H_ACTIVE) && (vcount<V_ACTIVE).
  - hsync asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - Asserted level = *_POL; deasserted = inverse.
- Cell coordinates:
  - sx = (hcount + scroll_x_latched) mod H_ACTIVE; sy = (vcount + scroll_y_latched) mod V_ACTIVE. Use wide enough arithmetic; scroll values >= ACTIVE are reduced modulo ACTIVE.
  - o_cell_col = sx mod CELL_W; o_text_col = sx / CELL_W; o_glyph_row = sy mod CELL_H; o_text_row = sy / CELL_H.
  - Outside the active area the coordinates are don't-care but must stay deterministic (computed by the same formula).
- Event pulses, each one clk wide and coincident with o_pix_en:
  - o_line_start when the new hcount = 0.
  - o_vblank_start when the new position = (0, V_ACTIVE).
- i_enable = 0: div and scan state freeze, o_pix_en = 0 and pulses = 0, all other outputs hold. Re-enable resumes from the frozen div value with no skipped pixel.
- Reset mid-frame: immediate return to reset values; the next run restarts from STARTUP.

Test Plan:
- Reset release, i_enable=1 -> first o_pix_en 4 clocks later; hcount=0, vcount=0, de=1, frame_count=0; o_pix_en period exactly 4 clocks.
- Run one line -> hsync=0 for hcount 656..751 (96 strobes); de=0 from hcount 640; line_start at hcount=0 only; line length 3200 clocks.
- Run one frame -> vsync=0 for vcount 490..491; vblank_start once at (0,480); frame_count=1 at second (0,0); frame = 1,680,000 clocks.
- scroll_x=3, scroll_y=0 applied before a frame boundary -> at hcount 0: cell_col=3, text_col=0; at hcount 5: cell_col=0, text_col=1. scroll_x=639 -> at hcount 1: text_col=0, cell_col=0. Mid-frame change ignored until the next frame.
- Small params (H_ACTIVE=16, porches 1/2/1, V_ACTIVE=8, porches 1/1/1, FRAME_W=2) -> frame_count sequence 0,1,2,3,0; HSYNC_POL=1 gives active-high hsync.
- i_enable=0 for 10 clocks mid-line -> outputs hold and no strobes; resume continues at hcount+1. rstn_i low mid-frame -> all outputs return to reset values asynchronously.
